// File: rtl/mux2to1_pkg.sv
// rtl/mux2to1_pkg.sv - shared limits and parameter legality check for mux2to1_reg
//
// Purpose:
//   Holds the legal parameter ranges of the registered 2:1 mux and a constant
//   function used at elaboration to reject illegal WIDTH/LATENCY pairs.
// Contents:
//   MAX_WIDTH    widest legal operand (bits)
//   MAX_LATENCY  deepest legal pipeline (register stages)
//   params_legal returns 1 when WIDTH and LATENCY are both in range

package mux2to1_pkg;

    localparam int MAX_WIDTH   = 64;
    localparam int MAX_LATENCY = 4;

    // A zero-latency build would expose a combinational input-to-output path,
    // so LATENCY has a lower bound of 1 as well as an upper bound.
    function automatic bit params_legal(input int width, input int latency);
        bit width_ok;
        bit latency_ok;
        width_ok   = (width >= 1) && (width <= MAX_WIDTH);
        latency_ok = (latency >= 1) && (latency <= MAX_LATENCY);
        return width_ok && latency_ok;
    endfunction

endpackage

// File: rtl/mux2to1_stage.sv
// rtl/mux2to1_stage.sv - one valid-gated register stage of the mux pipeline
//
// Purpose:
//   Registers WIDTH bits of data plus a valid bit. Data loads only when the
//   incoming valid is set; otherwise it holds, so the last valid result stays
//   visible downstream. The valid bit simply follows the incoming valid.
// Ports:
//   clk      input         rising-edge clock
//   rst_n    input         synchronous active-low reset, clears data and valid
//   data_i   input  WIDTH  data from the previous stage (or the select)
//   valid_i  input         qualifies data_i this cycle
//   data_o   output WIDTH  registered data
//   valid_o  output        registered valid

module mux2to1_stage
    import mux2to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_i;
        if (valid_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mux2to1_reg.sv
// rtl/mux2to1_reg.sv - registered, width-parameterised 2:1 mux with valid and pipeline depth
//
// Purpose:
//   Selects a (sel=0) or b (sel=1) bitwise and presents the result LATENCY
//   clock edges later through a chain of valid-gated register stages. Every
//   output comes straight from a flop, so there is no input-to-output
//   combinational path. No backpressure: the chain advances every cycle.
// Parameters:
//   WIDTH    1..64  operand/result width
//   LATENCY  1..4   register stages between inputs and y/out_valid
// Ports:
//   clk        input         rising-edge clock
//   rst_n      input         synchronous active-low reset, flushes all stages
//   a          input  WIDTH  operand selected when sel=0
//   b          input  WIDTH  operand selected when sel=1
//   sel        input         0 -> a, 1 -> b
//   in_valid   input         qualifies a/b/sel this cycle
//   y          output WIDTH  registered result, holds the last valid result
//   out_valid  output        y was produced from a valid input this cycle

module mux2to1_reg
    import mux2to1_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);

    if (!params_legal(WIDTH, LATENCY)) begin : g_bad_params
        $error("mux2to1_reg: WIDTH must be 1..%0d and LATENCY 1..%0d", MAX_WIDTH, MAX_LATENCY);
    end

    // Index 0 is the combinational select feeding the first stage; index n is
    // the output of register stage n.
    logic [LATENCY:0][WIDTH-1:0] stage_data;
    logic [LATENCY:0]            stage_valid;

    logic [WIDTH-1:0] sel_result;

    always_comb begin
        sel_result = a;
        if (sel) begin
            sel_result = b;
        end
    end

    assign stage_data[0]  = sel_result;
    assign stage_valid[0] = in_valid;

    for (genvar n = 0; n < LATENCY; n++) begin : g_stage
        mux2to1_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .data_i  (stage_data[n]),
            .valid_i (stage_valid[n]),
            .data_o  (stage_data[n+1]),
            .valid_o (stage_valid[n+1])
        );
    end

    assign y         = stage_data[LATENCY];
    assign out_valid = stage_valid[LATENCY];

endmodule

// File: tb/tb_mux2to1_reg.sv
// tb/tb_mux2to1_reg.sv - directed self-checking bench for mux2to1_reg

module tb_mux2to1_reg;

    logic clk;
    logic rst_n;

    // DUT 1: WIDTH=1, LATENCY=1
    logic       a1, b1, sel1, in_valid1;
    logic       y1, out_valid1;
    // DUT 2: WIDTH=8, LATENCY=1
    logic [7:0] a2, b2;
    logic       sel2, in_valid2;
    logic [7:0] y2;
    logic       out_valid2;
    // DUT 3: WIDTH=8, LATENCY=3
    logic [7:0] a3, b3;
    logic       sel3, in_valid3;
    logic [7:0] y3;
    logic       out_valid3;

    int checks;
    int errors;

    mux2to1_reg #(.WIDTH(1), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1),
        .in_valid(in_valid1), .y(y1), .out_valid(out_valid1)
    );

    mux2to1_reg #(.WIDTH(8), .LATENCY(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .sel(sel2),
        .in_valid(in_valid2), .y(y2), .out_valid(out_valid2)
    );

    mux2to1_reg #(.WIDTH(8), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .sel(sel3),
        .in_valid(in_valid3), .y(y3), .out_valid(out_valid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       exp1 [8];
    logic [2:0] vec;

    initial begin
        checks = 0;
        errors = 0;
        exp1 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0; in_valid1 = 1'b0;
        a2 = 8'h00; b2 = 8'h00; sel2 = 1'b0; in_valid2 = 1'b0;
        a3 = 8'h00; b3 = 8'h00; sel3 = 1'b0; in_valid3 = 1'b0;
        tick();
        tick();
        check("rst_y1",  64'(y1),         64'd0);
        check("rst_ov1", 64'(out_valid1), 64'd0);
        check("rst_y2",  64'(y2),         64'd0);
        check("rst_ov2", 64'(out_valid2), 64'd0);
        check("rst_y3",  64'(y3),         64'd0);
        check("rst_ov3", 64'(out_valid3), 64'd0);
        rst_n = 1'b1;

        // Truth table, W=1 L=1; vector order is {sel,a,b} counting up.
        in_valid1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vec  = 3'(i);
            sel1 = vec[2];
            a1   = vec[1];
            b1   = vec[0];
            tick();
            check($sformatf("tt_y%0d", i),  64'(y1),         64'(exp1[i]));
            check($sformatf("tt_ov%0d", i), 64'(out_valid1), 64'd1);
        end

        // Reset held with valid input present, then released.
        rst_n = 1'b0;
        in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b0; sel1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("hold_rst_y",  64'(y1),         64'd0);
            check("hold_rst_ov", 64'(out_valid1), 64'd0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_y",  64'(y1),         64'd1);
        check("post_rst_ov", 64'(out_valid1), 64'd1);

        // W=8 L=1 select both ways, then hold with in_valid low.
        in_valid2 = 1'b1; a2 = 8'hA5; b2 = 8'h3C; sel2 = 1'b0;
        tick();
        check("w8_sel0_y",  64'(y2),         64'hA5);
        check("w8_sel0_ov", 64'(out_valid2), 64'd1);
        sel2 = 1'b1;
        tick();
        check("w8_sel1_y",  64'(y2),         64'h3C);
        check("w8_sel1_ov", 64'(out_valid2), 64'd1);
        in_valid2 = 1'b0; a2 = 8'hFF; sel2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_y%0d", i),  64'(y2),         64'h3C);
            check($sformatf("hold_ov%0d", i), 64'(out_valid2), 64'd0);
        end

        // W=8 L=3 back-to-back stream.
        sel3 = 1'b0; b3 = 8'hEE; in_valid3 = 1'b1;
        a3 = 8'h01;
        tick();
        check("l3_e1_ov", 64'(out_valid3), 64'd0);
        a3 = 8'h02;
        tick();
        check("l3_e2_ov", 64'(out_valid3), 64'd0);
        a3 = 8'h03;
        tick();
        check("l3_e3_y",  64'(y3),         64'h01);
        check("l3_e3_ov", 64'(out_valid3), 64'd1);
        in_valid3 = 1'b0; a3 = 8'h55;
        tick();
        check("l3_e4_y",  64'(y3),         64'h02);
        check("l3_e4_ov", 64'(out_valid3), 64'd1);
        tick();
        check("l3_e5_y",  64'(y3),         64'h03);
        check("l3_e5_ov", 64'(out_valid3), 64'd1);
        tick();
        check("l3_e6_y",  64'(y3),         64'h03);
        check("l3_e6_ov", 64'(out_valid3), 64'd0);

        // Same stream, reset asserted after the second result emerges.
        in_valid3 = 1'b1;
        a3 = 8'h01;
        tick();
        a3 = 8'h02;
        tick();
        a3 = 8'h03;
        tick();
        check("l3r_e3_y", 64'(y3), 64'h01);
        in_valid3 = 1'b0;
        tick();
        check("l3r_e4_y", 64'(y3), 64'h02);
        rst_n = 1'b0;
        tick();
        check("l3r_rst_y",  64'(y3),         64'd0);
        check("l3r_rst_ov", 64'(out_valid3), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("l3r_flush_y%0d", i),  64'(y3),         64'd0);
            check($sformatf("l3r_flush_ov%0d", i), 64'(out_valid3), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
